// File: rtl/muxdff_pipe.sv
// NUM_IN:1 registered source select feeding an elastic STAGES-deep valid/ready pipeline.
// Flags select changes between consecutive samples and latches out-of-range selects.
module muxdff_pipe #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned NUM_IN = 4,
    parameter int unsigned STAGES = 2,
    localparam int unsigned SEL_W = $clog2(NUM_IN)
) (
    input  logic                      Clock,
    input  logic                      Resetn,
    input  logic [NUM_IN*WIDTH-1:0]   D,
    input  logic [SEL_W-1:0]          Sel,
    input  logic                      InValid,
    output logic                      InReady,
    output logic [WIDTH-1:0]          Q,
    output logic                      OutValid,
    input  logic                      OutReady,
    output logic                      SelChg,
    output logic                      SelErr
);

    logic [STAGES-1:0] valid_q, valid_d;
    logic [STAGES-1:0] chg_q, chg_d;
    logic [WIDTH-1:0]  data_q [STAGES];
    logic [WIDTH-1:0]  data_d [STAGES];
    logic [SEL_W-1:0]  prev_sel_q, prev_sel_d;
    logic              sel_err_q, sel_err_d;

    logic [STAGES:0]   stage_adv;
    logic [SEL_W-1:0]  sel_eff;
    logic              sel_oor;
    logic              accept;
    logic [WIDTH-1:0]  cap_data;

    always_comb begin
        sel_oor = (32'(Sel) >= NUM_IN);
        sel_eff = sel_oor ? '0 : Sel;
    end

    // Select through an explicit compare so no out-of-range part-select can occur.
    always_comb begin
        cap_data = D[WIDTH-1:0];
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            if (SEL_W'(k) == sel_eff) begin
                cap_data = D[k*WIDTH +: WIDTH];
            end
        end
    end

    // Unrolled form of advance_i = !valid_i | advance_{i+1}: any empty stage at or
    // downstream of i, or the consumer taking Q, lets stage i move.
    always_comb begin
        for (int unsigned i = 0; i <= STAGES; i++) begin
            stage_adv[i] = OutReady;
            for (int unsigned j = i; j < STAGES; j++) begin
                stage_adv[i] = stage_adv[i] | !valid_q[j];
            end
        end
    end

    always_comb begin
        InReady = stage_adv[0];
        accept  = InValid & stage_adv[0];
    end

    always_comb begin
        valid_d    = valid_q;
        chg_d      = chg_q;
        data_d     = data_q;
        prev_sel_d = prev_sel_q;
        sel_err_d  = sel_err_q;

        if (stage_adv[0]) begin
            valid_d[0] = InValid;
        end
        if (accept) begin
            data_d[0]  = cap_data;
            chg_d[0]   = (sel_eff != prev_sel_q);
            prev_sel_d = sel_eff;
            if (sel_oor) begin
                sel_err_d = 1'b1;
            end
        end

        for (int unsigned i = 1; i < STAGES; i++) begin
            if (stage_adv[i]) begin
                valid_d[i] = valid_q[i-1];
                if (valid_q[i-1]) begin
                    data_d[i] = data_q[i-1];
                    chg_d[i]  = chg_q[i-1];
                end
            end
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            valid_q    <= '0;
            chg_q      <= '0;
            prev_sel_q <= '0;
            sel_err_q  <= 1'b0;
            for (int unsigned i = 0; i < STAGES; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q    <= valid_d;
            chg_q      <= chg_d;
            prev_sel_q <= prev_sel_d;
            sel_err_q  <= sel_err_d;
            data_q     <= data_d;
        end
    end

    always_comb begin
        Q        = data_q[STAGES-1];
        OutValid = valid_q[STAGES-1];
        SelChg   = chg_q[STAGES-1];
        SelErr   = sel_err_q;
    end

endmodule
